// File: rtl/fp_decode_seq.sv
// fp_decode_seq: sequential decoder from the 8-bit FP word
// {sign, exp[2:0], sig[3:0]} to a 12-bit two's-complement value.
// The significand is widened, shifted left once per clock, and the sign is
// applied in a single negate step. Only one word is in flight at a time.
module fp_decode_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [2:0]  in_exp,
    input  logic [3:0]  in_sig,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_d,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        NEG   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    logic        sign_r;
    logic [11:0] mag_r;
    logic [2:0]  cnt_r;

    // Handshake and status flags come straight from the state register, so no
    // input can reach them combinationally.
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    // Decode sequence: capture, shift exp times, apply sign, present result.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sign_r <= 1'b0;
            mag_r  <= 12'h000;
            cnt_r  <= 3'd0;
            out_d  <= 12'h000;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r <= in_sign;
                        mag_r  <= {8'b0, in_sig};
                        cnt_r  <= in_exp;
                        state  <= (in_exp != 3'd0) ? SHIFT : NEG;
                    end
                end
                SHIFT: begin
                    mag_r <= mag_r << 1;
                    cnt_r <= cnt_r - 3'd1;
                    if (cnt_r == 3'd1) begin
                        state <= NEG;
                    end
                end
                NEG: begin
                    // 15 << 7 fits in 12 bits, so the negate can never wrap
                    // into a wrong sign; -0 naturally becomes 12'h000.
                    out_d <= sign_r ? (~mag_r + 12'd1) : mag_r;
                    state <= DONE;
                end
                DONE: begin
                    // out_d stays untouched here, holding the result under
                    // backpressure and after the handshake.
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
